// File: rtl/alu_core_pkg.sv
// alu_core_pkg: datapath width and logic-unit function codes shared by the ALU
package alu_core_pkg;
    localparam int ALU_WIDTH = 32;
    localparam logic [2:0] LF_AND   = 3'd0;
    localparam logic [2:0] LF_OR    = 3'd1;
    localparam logic [2:0] LF_XOR   = 3'd2;
    localparam logic [2:0] LF_NOR   = 3'd3;
    localparam logic [2:0] LF_NAND  = 3'd4;
    localparam logic [2:0] LF_XNOR  = 3'd5;
    localparam logic [2:0] LF_PASSA = 3'd6;
    localparam logic [2:0] LF_PASSB = 3'd7;
endpackage

// File: rtl/alu_core_rpadder32.sv
// rpadder32: 32-bit ripple-carry adder built from a chain of full adders
module rpadder32 (
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        cin,
    output logic [31:0] sum,
    output logic        cout
);
    logic [32:0] w_c;
    assign w_c[0] = cin;
    assign cout   = w_c[32];
    for (genvar g = 0; g < 32; g++) begin : g_fa
        assign sum[g]   = a[g] ^ b[g] ^ w_c[g];
        assign w_c[g+1] = (a[g] & b[g]) | (w_c[g] & (a[g] ^ b[g]));
    end
endmodule

// File: rtl/alu_core.sv
// alu_core: registered 32-bit add/logic ALU with NZCV flags; V is live only when ALU_CORE_OVERFLOW_EN is defined
module alu_core
    import alu_core_pkg::*;
#(
    parameter int WIDTH = ALU_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             invert_a,
    input  logic             invert_b,
    input  logic             is_logic,
    input  logic [2:0]       logic_func_idx,
    input  logic             cin,
    input  logic             isactive,
    output logic [WIDTH-1:0] result,
    output logic             N,
    output logic             Z,
    output logic             C,
    output logic             V,
    output logic             out_valid
);
    logic [WIDTH-1:0] w_ea, w_eb, w_sum, w_logic, w_res;
    logic             w_cout, w_c, w_v;

    assign w_ea = a ^ {WIDTH{invert_a}};
    assign w_eb = b ^ {WIDTH{invert_b}};

    rpadder32 u_add (
        .a   (w_ea),
        .b   (w_eb),
        .cin (cin),
        .sum (w_sum),
        .cout(w_cout)
    );

    // logic unit: select one of eight bitwise functions of the effective operands
    always_comb begin
        w_logic = w_ea;
        case (logic_func_idx)
            LF_AND:   w_logic = w_ea & w_eb;
            LF_OR:    w_logic = w_ea | w_eb;
            LF_XOR:   w_logic = w_ea ^ w_eb;
            LF_NOR:   w_logic = ~(w_ea | w_eb);
            LF_NAND:  w_logic = ~(w_ea & w_eb);
            LF_XNOR:  w_logic = ~(w_ea ^ w_eb);
            LF_PASSA: w_logic = w_ea;
            LF_PASSB: w_logic = w_eb;
        endcase
    end

    assign w_res = is_logic ? w_logic : w_sum;
    assign w_c   = ~is_logic & w_cout;
`ifdef ALU_CORE_OVERFLOW_EN
    assign w_v = ~is_logic & (w_ea[WIDTH-1] == w_eb[WIDTH-1]) & (w_sum[WIDTH-1] != w_ea[WIDTH-1]);
`else
    assign w_v = 1'b0;
`endif

    // capture result and flags when active; out_valid marks the edge that updated them
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            result    <= '0;
            N         <= 1'b0;
            Z         <= 1'b0;
            C         <= 1'b0;
            V         <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            out_valid <= isactive;
            if (isactive) begin
                result <= w_res;
                N      <= w_res[WIDTH-1];
                Z      <= ~|w_res;
                C      <= w_c;
                V      <= w_v;
            end
        end
    end
endmodule

// File: tb/tb_alu_core.sv
// tb_alu_core: vector table, randomized model comparison and reset/hold sequences for alu_core
module tb_alu_core;
    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic [31:0] a = '0, b = '0;
    logic        invert_a = 1'b0, invert_b = 1'b0, is_logic = 1'b0, cin = 1'b0, isactive = 1'b0;
    logic [2:0]  logic_func_idx = '0;
    logic [31:0] result;
    logic        N, Z, C, V, out_valid;
    int          n_chk = 0, n_err = 0;

`ifdef ALU_CORE_OVERFLOW_EN
    localparam logic OV = 1'b1;
`else
    localparam logic OV = 1'b0;
`endif

    alu_core dut (
        .clk(clk), .rst_n(rst_n), .a(a), .b(b), .invert_a(invert_a), .invert_b(invert_b),
        .is_logic(is_logic), .logic_func_idx(logic_func_idx), .cin(cin), .isactive(isactive),
        .result(result), .N(N), .Z(Z), .C(C), .V(V), .out_valid(out_valid)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] a, b;
        logic        ia, ib, il;
        logic [2:0]  f;
        logic        ci;
        logic [31:0] er;
        logic [3:0]  ef;
    } vec_t;

    vec_t tbl[14];

    function automatic vec_t mk(input logic [31:0] a_, b_, input logic ia, ib, il,
                                input logic [2:0] f, input logic ci, input logic [31:0] er,
                                input logic [3:0] ef);
        vec_t v;
        v.a = a_; v.b = b_; v.ia = ia; v.ib = ib; v.il = il; v.f = f; v.ci = ci; v.er = er; v.ef = ef;
        return v;
    endfunction

    // reference: {result, N, Z, C, V} from plain integer arithmetic
    function automatic logic [35:0] model(input logic [31:0] a_, b_, input logic ia, ib, il,
                                          input logic [2:0] f, input logic ci);
        logic [31:0] ea, eb, r;
        logic [32:0] t;
        logic        c, v;
        longint      s;
        ea = ia ? ~a_ : a_;
        eb = ib ? ~b_ : b_;
        c = 1'b0;
        v = 1'b0;
        if (il) begin
            case (f)
                3'd0: r = ea & eb;
                3'd1: r = ea | eb;
                3'd2: r = ea ^ eb;
                3'd3: r = ~(ea | eb);
                3'd4: r = ~(ea & eb);
                3'd5: r = ~(ea ^ eb);
                3'd6: r = ea;
                default: r = eb;
            endcase
        end else begin
            t = {1'b0, ea} + {1'b0, eb} + {32'd0, ci};
            r = t[31:0];
            c = t[32];
            s = longint'($signed(ea)) + longint'($signed(eb)) + longint'(ci);
            v = OV && (s > 64'sd2147483647 || s < -64'sd2147483648);
        end
        return {r, r[31], r == 32'd0, c, v};
    endfunction

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h", nm, got, exp);
        end
    endtask

    task automatic drive(input logic [31:0] a_, b_, input logic ia, ib, il,
                         input logic [2:0] f, input logic ci, input logic act);
        a = a_; b = b_; invert_a = ia; invert_b = ib; is_logic = il;
        logic_func_idx = f; cin = ci; isactive = act;
    endtask

    initial begin
        logic [35:0] exp;
        logic        exp_vld;
        logic [31:0] ra, rb;
        logic        ria, rib, ril, rci, ract;
        logic [2:0]  rf;

        tbl[0]  = mk(32'd5, 32'd3, 0, 0, 0, 3'd0, 0, 32'd8, 4'b0000);
        tbl[1]  = mk(32'd3, 32'd5, 0, 1, 0, 3'd0, 1, 32'hFFFFFFFE, 4'b1000);
        tbl[2]  = mk(32'h1234, 32'h1234, 0, 1, 0, 3'd0, 1, 32'd0, 4'b0110);
        tbl[3]  = mk(32'h7FFFFFFF, 32'd1, 0, 0, 0, 3'd0, 0, 32'h80000000, {3'b100, OV});
        tbl[4]  = mk(32'hFFFFFFFF, 32'd1, 0, 0, 0, 3'd0, 0, 32'd0, 4'b0110);
        tbl[5]  = mk(32'hF0F0F0F0, 32'hFF00FF00, 0, 0, 1, 3'd0, 0, 32'hF000F000, 4'b1000);
        tbl[6]  = mk(32'hF0F0F0F0, 32'hFF00FF00, 0, 0, 1, 3'd1, 0, 32'hFFF0FFF0, 4'b1000);
        tbl[7]  = mk(32'hF0F0F0F0, 32'hFF00FF00, 0, 0, 1, 3'd2, 0, 32'h0FF00FF0, 4'b0000);
        tbl[8]  = mk(32'hF0F0F0F0, 32'hFF00FF00, 0, 0, 1, 3'd3, 0, 32'h000F000F, 4'b0000);
        tbl[9]  = mk(32'hF0F0F0F0, 32'hFF00FF00, 0, 0, 1, 3'd4, 1, 32'h0FFF0FFF, 4'b0000);
        tbl[10] = mk(32'hF0F0F0F0, 32'hFF00FF00, 0, 0, 1, 3'd5, 0, 32'hF00FF00F, 4'b1000);
        tbl[11] = mk(32'hF0F0F0F0, 32'hFF00FF00, 0, 0, 1, 3'd6, 0, 32'hF0F0F0F0, 4'b1000);
        tbl[12] = mk(32'h0F0F0F0F, 32'h00FF00FF, 1, 1, 1, 3'd7, 0, 32'hFF00FF00, 4'b1000);
        tbl[13] = mk(32'hF0F0F0F0, 32'hFF00FF00, 0, 0, 1, 3'd7, 0, 32'hFF00FF00, 4'b1000);

        #1 rst_n = 1'b0;
        #1;
        chk("reset_result", result, 32'd0);
        chk("reset_flags", {28'd0, N, Z, C, V}, 32'd0);
        chk("reset_valid", {31'd0, out_valid}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 14; i++) begin
            drive(tbl[i].a, tbl[i].b, tbl[i].ia, tbl[i].ib, tbl[i].il, tbl[i].f, tbl[i].ci, 1'b1);
            @(negedge clk);
            chk($sformatf("vec%0d_result", i), result, tbl[i].er);
            chk($sformatf("vec%0d_nzcv", i), {28'd0, N, Z, C, V}, {28'd0, tbl[i].ef});
            chk($sformatf("vec%0d_valid", i), {31'd0, out_valid}, 32'd1);
        end

        drive(32'h12345678, 32'h9ABCDEF0, 1, 0, 0, 3'd2, 1, 1'b0);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            chk("hold_result", result, 32'hFF00FF00);
            chk("hold_nzcv", {28'd0, N, Z, C, V}, 32'b1000);
            chk("hold_valid", {31'd0, out_valid}, 32'd0);
        end

        exp = {32'hFF00FF00, 4'b1000};
        exp_vld = 1'b0;
        for (int i = 0; i < 300; i++) begin
            ra = (i % 7 == 0) ? 32'h7FFFFFFF : $urandom;
            rb = (i % 11 == 0) ? 32'h80000000 : $urandom;
            ria = 1'($urandom); rib = 1'($urandom); ril = 1'($urandom);
            rf = 3'($urandom); rci = 1'($urandom);
            ract = ($urandom_range(0, 3) != 0);
            drive(ra, rb, ria, rib, ril, rf, rci, ract);
            if (ract) exp = model(ra, rb, ria, rib, ril, rf, rci);
            exp_vld = ract;
            @(negedge clk);
            chk("rand_result", result, exp[35:4]);
            chk("rand_nzcv", {28'd0, N, Z, C, V}, {28'd0, exp[3:0]});
            chk("rand_valid", {31'd0, out_valid}, {31'd0, exp_vld});
        end

        drive(32'h7FFFFFFF, 32'd1, 0, 0, 0, 3'd0, 0, 1'b1);
        @(negedge clk);
        drive(32'hFFFFFFFF, 32'd1, 0, 0, 0, 3'd0, 0, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_result", result, 32'd0);
        chk("midrst_flags", {28'd0, N, Z, C, V}, 32'd0);
        chk("midrst_valid", {31'd0, out_valid}, 32'd0);
        @(negedge clk);
        chk("inrst_result", result, 32'd0);
        chk("inrst_valid", {31'd0, out_valid}, 32'd0);
        rst_n = 1'b1;
        drive(32'd7, 32'd1, 0, 0, 0, 3'd0, 0, 1'b1);
        @(negedge clk);
        chk("first_cap_result", result, 32'd8);
        chk("first_cap_valid", {31'd0, out_valid}, 32'd1);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule

// File: doc/alu_core.md
ALU_CORE -- requirements
Module: alu_core

Interface
REQ-001 Parameter: WIDTH, default 32, datapath width; only the value 32 is supported.
REQ-002 The block SHALL use one clock and an asynchronous, active-low reset.
REQ-003 Port clk, input, 1 bit: rising-edge clock.
REQ-004 Port rst_n, input, 1 bit: asynchronous active-low reset.
REQ-005 Port a, input, 32 bits: operand A.
REQ-006 Port b, input, 32 bits: operand B.
REQ-007 Port invert_a, input, 1 bit: use bitwise NOT of a as the effective operand A.
REQ-008 Port invert_b, input, 1 bit: use bitwise NOT of b as the effective operand B.
REQ-009 Port is_logic, input, 1 bit: 1 selects the logic unit, 0 selects the adder.
REQ-010 Port logic_func_idx, input, 3 bits: logic function select.
REQ-011 Port cin, input, 1 bit: adder carry-in.
REQ-012 Port isactive, input, 1 bit: capture enable.
REQ-013 Port result, output, 32 bits: registered result.
REQ-014 Ports N, Z, C and V, outputs, 1 bit each: registered flags.
REQ-015 Port out_valid, output, 1 bit: result and flags were updated by the last clock edge.

Function
REQ-016 Effective operands SHALL be: ea = invert_a ? ~a : a; eb = invert_b ? ~b : b. Inversion is a 32-bit XOR with all-ones.
REQ-017 Adder path SHALL compute {C_add, sum} = ea + eb + cin, unsigned, 33 bits.
REQ-018 Adder usage: subtraction a-b is invert_b=1 with cin=1.
REQ-019 Logic path function codes SHALL be: 0 AND, 1 OR, 2 XOR, 3 NOR, 4 NAND, 5 XNOR, 6 pass ea, 7 pass eb.
REQ-020 On a rising clk edge with isactive=1, result SHALL load is_logic ? logic_out : sum.
REQ-021 On that same edge, out_valid SHALL be set to 1.
REQ-022 Latency from operand capture to result SHALL be exactly 1 cycle.
REQ-023 With isactive=1 every cycle, the block SHALL accept a new operation every cycle.
REQ-024 On an edge with isactive=0, result, N, Z, C and V SHALL hold their values, and out_valid SHALL load 0.
REQ-025 N SHALL be the new result[31].
REQ-026 Z SHALL be 1 exactly when the new result equals 0.
REQ-027 In arithmetic mode, C SHALL be C_add; in logic mode, C SHALL be 0.
REQ-028 V SHALL be 1 when ea[31]==eb[31] and sum[31]!=ea[31], in arithmetic mode only; in logic mode V SHALL be 0.
REQ-029 Boundary cases: 0xFFFFFFFF+1 SHALL wrap to result 0 with Z=1 and C=1; 0x7FFFFFFF+1 SHALL give V=1 and N=1.
REQ-030 Inputs SHALL be sampled only at the clock edge; there are no internal delays and no combinational input-to-output path.

Reset
REQ-031 While rst_n=0, result SHALL be 0, N, Z, C and V SHALL be 0, and out_valid SHALL be 0, all asynchronously.
REQ-032 Reset asserted mid-stream SHALL discard any in-flight capture.
REQ-033 The first capture after reset SHALL occur on the first rising edge with rst_n=1 and isactive=1.

Configuration
REQ-034 Macro ALU_CORE_OVERFLOW_EN defined: V SHALL be computed per REQ-028.
REQ-035 Macro ALU_CORE_OVERFLOW_EN undefined: V SHALL be tied to 0, no overflow logic SHALL be synthesised, and all other behaviour SHALL be unchanged.

Structure
REQ-036 Package alu_core_pkg SHALL hold the WIDTH constant and the eight logic function code constants (LF_AND ... LF_PASSB).
REQ-037 Sub-module rpadder32 SHALL implement the 32-bit ripple-carry adder from a generate loop of full adders, with ports a, b, cin, sum, cout.
REQ-038 The inverter, the logic unit, the flags and the registers SHALL live in alu_core.

Verification
REQ-039 Reset check: rst_n=0 at any time -> next sample shows result=0, N=Z=C=V=0 and out_valid=0, without a clock edge.
REQ-040 Add: a=5, b=3, cin=0, isactive=1 -> one cycle later result=8, N=Z=C=V=0, out_valid=1.
REQ-041 Subtract: a=3, b=5, invert_b=1, cin=1 -> result=0xFFFFFFFE, N=1, C=0, V=0.
REQ-042 Equal subtract: a=b=0x1234, invert_b=1, cin=1 -> result=0, Z=1, C=1.
REQ-043 Overflow: a=0x7FFFFFFF, b=1, cin=0 -> result=0x80000000, N=1, V=1, C=0; with ALU_CORE_OVERFLOW_EN undefined -> V=0.
REQ-044 Logic sweep and hold: a=0xF0F0F0F0, b=0xFF00FF00, is_logic=1, idx 0..7 -> result 0xF000F000, 0xFFF0FFF0, 0x0FF00FF0, 0x000F000F, 0x0FFF0FFF, 0xF00FF00F, 0xF0F0F0F0, 0xFF00FF00 with C=V=0; then isactive=0 with changed inputs -> outputs hold and out_valid=0.
